// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/issue sequencer feeding the execution unit
//
// Holds the PC, reads 16-bit instructions from a synchronous instruction
// memory, and presents decoded fields to the EU. JMP, BRZ and HALT are
// resolved here and never issued. Each instruction takes four cycles:
// FETCH -> DECODE -> EXEC -> RETIRE. HALT is terminal until reset.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   imem_addr    instruction memory read address (the PC)
//   imem_data    instruction word, valid one cycle after imem_addr
//   opA_data     register read data for opAAdr, used by BRZ
//   opcode       opcode to the EU, 0 outside EXEC
//   opAAdr       operand A register address (instr[8:6])
//   opBAder      operand B register address (instr[5:3])
//   dest_reg     destination register (instr[11:9])
//   dmem_addr    data memory address for LOAD/STORE (instr[5:0])
//   issue        high only in the EXEC cycle of an EU-bound instruction
//   halted       high while in HALT
//   instr_count  retired-instruction counter, saturating

module control_unit #(
    parameter int         PC_WIDTH = 8,
    parameter logic [3:0] OP_HALT  = 4'hF,
    parameter logic [3:0] OP_JMP   = 4'hE,
    parameter logic [3:0] OP_BRZ   = 4'hD,
    parameter logic [3:0] OP_LOAD  = 4'h4,
    parameter logic [3:0] OP_STORE = 4'h5
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    input  logic [7:0]          opA_data,
    output logic [3:0]          opcode,
    output logic [2:0]          opAAdr,
    output logic [2:0]          opBAder,
    output logic [2:0]          dest_reg,
    output logic [5:0]          dmem_addr,
    output logic                issue,
    output logic                halted,
    output logic [15:0]         instr_count
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_RETIRE,
        S_HALT
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;
    logic                take_branch;

    logic [3:0]          ir_op;
    logic [3:0]          fetched_op;
    logic [PC_WIDTH-1:0] target;

    assign ir_op      = ir[15:12];
    assign fetched_op = imem_data[15:12];
    assign target     = PC_WIDTH'(ir[7:0]);

    // The PC register addresses the synchronous memory directly; it only
    // changes in RETIRE, so it is stable across FETCH and DECODE.
    assign imem_addr = pc;

    // Field outputs come straight from the instruction register. They are
    // meaningful only while issue is high; downstream qualifies on issue.
    assign dest_reg  = ir[11:9];
    assign opAAdr    = ir[8:6];
    assign opBAder   = ir[5:3];
    assign dmem_addr = ir[5:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= '0;
            ir          <= '0;
            take_branch <= 1'b0;
            opcode      <= 4'h0;
            issue       <= 1'b0;
            halted      <= 1'b0;
            instr_count <= 16'h0000;
        end else begin
            case (state)
                S_FETCH: begin
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    // Load opcode/issue on this edge so they are valid for
                    // the whole EXEC cycle.
                    ir     <= imem_data;
                    opcode <= fetched_op;
                    issue  <= !(fetched_op == OP_JMP  ||
                                fetched_op == OP_BRZ  ||
                                fetched_op == OP_HALT);
                    state  <= S_EXEC;
                end

                S_EXEC: begin
                    opcode      <= 4'h0;
                    issue       <= 1'b0;
                    // opA_data is the register read for opAAdr during EXEC.
                    take_branch <= (ir_op == OP_BRZ) && (opA_data == 8'h00);
                    state       <= S_RETIRE;
                end

                S_RETIRE: begin
                    if (instr_count != 16'hFFFF) begin
                        instr_count <= instr_count + 16'h0001;
                    end
                    take_branch <= 1'b0;
                    if (ir_op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        if (ir_op == OP_JMP || take_branch) begin
                            pc <= target;
                        end else begin
                            pc <= pc + PC_WIDTH'(1);
                        end
                        state <= S_FETCH;
                    end
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
